// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the EXE->MEM skid stage.
//   - Default datapath / register-number / stall-counter widths.
//   - FSM state encoding (2 bits): EMPTY, FULL, SKID.
//   - bundle_w(): width of one packed bundle, laid out MSB->LSB as
//     {wreg, m2reg, wmem, rn[RW], alu[DW], qb[DW]}.
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int DW_DEF    = 32;
  localparam int RW_DEF    = 5;
  localparam int CNT_W_DEF = 16;

  typedef logic [1:0] state_t;

  localparam state_t EMPTY = 2'd0;  // nothing buffered
  localparam state_t FULL  = 2'd1;  // output slot holds a bundle
  localparam state_t SKID  = 2'd2;  // output slot and skid slot both hold a bundle

  // Three control bits, the destination register, ALU result and store data.
  function automatic int bundle_w(input int dw, input int rw);
    return 3 + rw + 2 * dw;
  endfunction

endpackage

// File: rtl/exe_mem_skid_if.sv
// ---------------------------------------------------------------------------
// exe_mem_skid_if
// One valid/ready bundle channel between two pipeline stages.
//   valid  producer -> consumer   bundle present
//   ready  consumer -> producer   bundle accepted this cycle
//   wreg   register-write enable
//   m2reg  select memory data for write-back
//   wmem   data-memory write enable
//   rn     destination register
//   alu    ALU result / memory address
//   qb     store data
// Modports: master = producer side, slave = consumer side.
// ---------------------------------------------------------------------------
interface exe_mem_skid_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          valid;
  logic          ready;
  logic          wreg;
  logic          m2reg;
  logic          wmem;
  logic [RW-1:0] rn;
  logic [DW-1:0] alu;
  logic [DW-1:0] qb;

  modport master (output valid, wreg, m2reg, wmem, rn, alu, qb, input  ready);
  modport slave  (input  valid, wreg, m2reg, wmem, rn, alu, qb, output ready);
endinterface

// File: rtl/pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
// Enable-load register holding one packed bundle.
//   clk  in   clock
//   rst  in   asynchronous active-high reset (clears the slot)
//   ld   in   load d on the next rising edge
//   d    in   W  bundle to store
//   q    out  W  stored bundle
// ---------------------------------------------------------------------------
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: data registers are reset too, so every output is defined
  // immediately after reset rather than only the valid bit.
  // NOTE: sequential state uses non-blocking assignment so all flops
  // update together at the edge, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/exe_mem_skid.sv
// ---------------------------------------------------------------------------
// exe_mem_skid
// EXE->MEM pipeline register built as a 2-entry skid buffer. e.ready is a
// flop, so a stalling data memory never creates a combinational path from
// m.ready back into EXE.
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   e          slave  modport: bundle from EXE (valid/ready + fields)
//   m          master modport: bundle to MEM  (valid/ready + fields)
//   flush      in   drop every buffered bundle and any same-cycle accept
//   stall_cnt  out  CNT_W  cycles with m.valid & !m.ready, saturating
// ---------------------------------------------------------------------------
module exe_mem_skid
  import pipe_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int RW    = RW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  exe_mem_skid_if.slave    e,
  exe_mem_skid_if.master   m,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int BW = bundle_w(DW, RW);

  state_t        state;
  logic          e_ready_q;
  logic          m_valid_q;
  logic          accept;
  logic          consume;
  logic          out_ld;
  logic          skid_ld;
  logic [BW-1:0] e_bundle;
  logic [BW-1:0] out_d;
  logic [BW-1:0] out_q;
  logic [BW-1:0] skid_q;

  logic          o_wreg;
  logic          o_m2reg;
  logic          o_wmem;
  logic [RW-1:0] o_rn;
  logic [DW-1:0] o_alu;
  logic [DW-1:0] o_qb;

  assign accept   = e.valid & e_ready_q;
  assign consume  = m_valid_q & m.ready;
  assign e_bundle = {e.wreg, e.m2reg, e.wmem, e.rn, e.alu, e.qb};

  // Slot load steering. Flush suppresses every load so a bundle arriving
  // alongside it can never reach the outputs.
  // NOTE: every signal gets a default before the case, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    out_ld  = 1'b0;
    skid_ld = 1'b0;
    out_d   = e_bundle;
    if (!flush) begin
      case (state)
        EMPTY: out_ld = accept;
        FULL: begin
          out_ld  = accept & consume;
          skid_ld = accept & ~consume;
        end
        SKID: begin
          out_ld = consume;
          out_d  = skid_q;
        end
        default: ;
      endcase
    end
  end

  pipe_slot #(.W(BW)) u_out_slot (
    .clk (clk),
    .rst (rst),
    .ld  (out_ld),
    .d   (out_d),
    .q   (out_q)
  );

  pipe_slot #(.W(BW)) u_skid_slot (
    .clk (clk),
    .rst (rst),
    .ld  (skid_ld),
    .d   (e_bundle),
    .q   (skid_q)
  );

  // Control FSM with registered e_ready / m_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      e_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      e_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= FULL;
            m_valid_q <= 1'b1;
          end
        end
        FULL: begin
          if (accept && !consume) begin
            state     <= SKID;
            e_ready_q <= 1'b0;
          end else if (!accept && consume) begin
            state     <= EMPTY;
            m_valid_q <= 1'b0;
          end
        end
        SKID: begin
          if (consume) begin
            state     <= FULL;
            e_ready_q <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          e_ready_q <= 1'b1;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating stall counter; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (m_valid_q && !m.ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign {o_wreg, o_m2reg, o_wmem, o_rn, o_alu, o_qb} = out_q;

  assign e.ready = e_ready_q;
  assign m.valid = m_valid_q;
  // Write enables are gated so a flushed or empty slot can never write.
  assign m.wreg  = o_wreg & m_valid_q;
  assign m.wmem  = o_wmem & m_valid_q;
  assign m.m2reg = o_m2reg;
  assign m.rn    = o_rn;
  assign m.alu   = o_alu;
  assign m.qb    = o_qb;

endmodule

// File: tb/tb_exe_mem_skid.sv
// ---------------------------------------------------------------------------
// tb_exe_mem_skid
// Directed bench for exe_mem_skid. Stimulus pushes the expected bundle into
// a scoreboard queue; a monitor pops and compares on each consume.
// ---------------------------------------------------------------------------
module tb_exe_mem_skid;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [4:0]  rn;
    logic [31:0] alu;
    logic [31:0] qb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [3:0] stall_cnt;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  exe_mem_skid_if #(.DW(32), .RW(5)) e_if ();
  exe_mem_skid_if #(.DW(32), .RW(5)) m_if ();

  exe_mem_skid #(.DW(32), .RW(5), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .e         (e_if.slave),
    .m         (m_if.master),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a bundle on the EXE side; queue it only if it should survive.
  task automatic drive(input logic [31:0] r, input logic [4:0] rn, input logic wr,
                       input logic m2, input logic wm, input logic [31:0] qb, input bit keep);
    exp_t x;
    e_if.valid = 1'b1;
    e_if.alu   = r;
    e_if.rn    = rn;
    e_if.wreg  = wr;
    e_if.m2reg = m2;
    e_if.wmem  = wm;
    e_if.qb    = qb;
    x = '{wreg: wr, m2reg: m2, wmem: wm, rn: rn, alu: r, qb: qb};
    if (keep) sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consume must match the oldest expected bundle.
  always @(negedge clk) begin
    if (!rst && m_if.valid && m_if.ready) begin
      if (sb.size() == 0) begin
        check("mon_unexpected_bundle", {64'd0, m_if.alu[7:0]}, 72'd0);
      end else begin
        exp_t x;
        exp_t a;
        x = sb.pop_front();
        a = '{wreg: m_if.wreg, m2reg: m_if.m2reg, wmem: m_if.wmem,
              rn: m_if.rn, alu: m_if.alu, qb: m_if.qb};
        check("mon_bundle", a, x);
      end
    end
  end

  initial begin
    e_if.valid = 1'b0;
    e_if.alu   = '0;
    e_if.rn    = '0;
    e_if.wreg  = 1'b0;
    e_if.m2reg = 1'b0;
    e_if.wmem  = 1'b0;
    e_if.qb    = '0;
    m_if.ready = 1'b0;

    // ---- reset ----
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_e_ready", 72'(e_if.ready), 72'd1);
    check("rst_m_valid", 72'(m_if.valid), 72'd0);
    check("rst_stall_cnt", 72'(stall_cnt), 72'd0);
    check("rst_malu", 72'(m_if.alu), 72'd0);

    // ---- stall counter + write-enable gating ----
    tick();
    drive(32'h0000_0005, 5'd4, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    tick();
    e_if.valid = 1'b0;
    @(negedge clk);
    check("stall_m_valid", 72'(m_if.valid), 72'd1);
    check("stall_cnt_0", 72'(stall_cnt), 72'd0);
    check("gate_wreg_on", 72'(m_if.wreg), 72'd1);
    check("gate_wmem_on", 72'(m_if.wmem), 72'd1);
    check("stall_malu", 72'(m_if.alu), 72'h5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stall_cnt_5", 72'(stall_cnt), 72'd5);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("stall_cnt_sat", 72'(stall_cnt), 72'd15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_m_valid", 72'(m_if.valid), 72'd0);
    check("gate_wreg_off", 72'(m_if.wreg), 72'd0);
    check("gate_wmem_off", 72'(m_if.wmem), 72'd0);
    check("flush_keeps_cnt", 72'(stall_cnt), 72'd15);

    // ---- streaming with m_ready=1 ----
    m_if.ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(32'(16 * (i + 1)), 5'(8 + i), 1'b1, 1'b0, 1'b0, 32'(100 + i), 1'b1);
      @(negedge clk);
      check("stream_e_ready", 72'(e_if.ready), 72'd1);
      if (i > 0) check("stream_malu", 72'(m_if.alu), 72'(16 * i));
      tick();
    end
    e_if.valid = 1'b0;
    @(negedge clk);
    check("stream_malu_last", 72'(m_if.alu), 72'h30);
    check("stream_mrn_last", 72'(m_if.rn), 72'd10);
    tick();
    @(negedge clk);
    check("stream_drained", 72'(m_if.valid), 72'd0);

    // ---- skid: A then B with m_ready=0 ----
    m_if.ready = 1'b0;
    tick();
    drive(32'hAAAA_0001, 5'd3, 1'b1, 1'b1, 1'b0, 32'hCAFE_0001, 1'b1);
    tick();
    drive(32'hBBBB_0002, 5'd7, 1'b0, 1'b0, 1'b1, 32'hCAFE_0002, 1'b1);
    @(negedge clk);
    check("skid_full_e_ready", 72'(e_if.ready), 72'd1);
    tick();
    e_if.valid = 1'b0;
    @(negedge clk);
    check("skid_e_ready", 72'(e_if.ready), 72'd0);
    check("skid_m_valid", 72'(m_if.valid), 72'd1);
    check("skid_malu_a", 72'(m_if.alu), 72'hAAAA_0001);
    tick();
    m_if.ready = 1'b1;
    tick();
    @(negedge clk);
    check("skid_malu_b", 72'(m_if.alu), 72'hBBBB_0002);
    check("skid_refill_e_ready", 72'(e_if.ready), 72'd1);
    tick();
    @(negedge clk);
    check("skid_drained", 72'(m_if.valid), 72'd0);

    // ---- flush in SKID with C presented ----
    m_if.ready = 1'b0;
    tick();
    drive(32'h1111_0001, 5'd1, 1'b1, 1'b0, 1'b1, 32'h1, 1'b0);
    tick();
    drive(32'h2222_0002, 5'd2, 1'b1, 1'b0, 1'b1, 32'h2, 1'b0);
    tick();
    drive(32'hCCCC_0003, 5'd12, 1'b1, 1'b0, 1'b1, 32'h3, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check("pre_flush_skid", 72'(e_if.ready), 72'd0);
    tick();
    flush = 1'b0;
    e_if.valid = 1'b0;
    @(negedge clk);
    check("skid_flush_m_valid", 72'(m_if.valid), 72'd0);
    check("skid_flush_mwreg", 72'(m_if.wreg), 72'd0);
    check("skid_flush_mwmem", 72'(m_if.wmem), 72'd0);
    check("skid_flush_e_ready", 72'(e_if.ready), 72'd1);

    // ---- flush in FULL while C would otherwise be accepted ----
    tick();
    drive(32'h4444_0004, 5'd4, 1'b1, 1'b0, 1'b0, 32'h4, 1'b0);
    tick();
    drive(32'hCCCC_0005, 5'd13, 1'b1, 1'b0, 1'b1, 32'h5, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    e_if.valid = 1'b0;
    m_if.ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("c_never_appears", 72'(m_if.valid), 72'd0);
      tick();
    end

    // ---- reset asserted mid-stall ----
    m_if.ready = 1'b0;
    drive(32'h5555_0006, 5'd6, 1'b1, 1'b0, 1'b1, 32'h6, 1'b0);
    tick();
    e_if.valid = 1'b0;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_m_valid", 72'(m_if.valid), 72'd0);
    check("midrst_malu", 72'(m_if.alu), 72'd0);
    check("midrst_stall_cnt", 72'(stall_cnt), 72'd0);
    check("midrst_e_ready", 72'(e_if.ready), 72'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_e_ready", 72'(e_if.ready), 72'd1);
    check("post_rst_m_valid", 72'(m_if.valid), 72'd0);

    check("scoreboard_empty", 72'(sb.size()), 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
